// File: rtl/seg7_pkg.sv
// Shared constants and the BCD-to-segment code table for the 4-digit
// multiplexed seven-segment display.
package seg7_pkg;

   localparam int         NUM_DIGITS = 4;
   localparam logic [6:0] SEG_BLANK  = 7'h7F;

   // Active-low segment codes, bit 0 = a ... bit 6 = g; 10..15 render blank.
   function automatic logic [6:0] seg7_code(input logic [3:0] bcd);
      logic [6:0] code;
      case (bcd)
         4'd0:    code = 7'h40;
         4'd1:    code = 7'h79;
         4'd2:    code = 7'h24;
         4'd3:    code = 7'h30;
         4'd4:    code = 7'h19;
         4'd5:    code = 7'h12;
         4'd6:    code = 7'h02;
         4'd7:    code = 7'h78;
         4'd8:    code = 7'h00;
         4'd9:    code = 7'h10;
         default: code = SEG_BLANK;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Bundles the load handshake and the display drive lines of seg7_scan_display.
interface seg7_scan_display_if;
   import seg7_pkg::*;

   // Handshake: load is a single-cycle strobe with no back-pressure; every
   // strobe is captured on its edge and answered by a one-cycle load_ack on
   // the following cycle, so the master may strobe on consecutive cycles.
   logic [4*NUM_DIGITS-1:0] digit_in;
   logic                    load;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    blank_lz;
   logic                    blink_en;
   logic                    load_ack;
   logic [6:0]              seg_n;
   logic                    dp_n;
   logic [NUM_DIGITS-1:0]   an_n;

   modport master (
      output digit_in, load, dp_in, blank_lz, blink_en,
      input  load_ack, seg_n, dp_n, an_n
   );

   modport slave (
      input  digit_in, load, dp_in, blank_lz, blink_en,
      output load_ack, seg_n, dp_n, an_n
   );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder; 10..15 are blank.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   assign seg_n = seg7_code(bcd);

endmodule

// File: rtl/seg7_scan_display.sv
// Four-digit multiplexed seven-segment driver with shadow capture,
// leading-zero blanking, per-digit decimal points, dead time and blink.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int CLK_HZ   = 50000000,
   parameter int SCAN_HZ  = 1000,
   parameter int BLINK_HZ = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digit_in,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   input  logic                    blink_en,
   output logic                    load_ack,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n
);

   localparam int DIV  = CLK_HZ / SCAN_HZ;
   localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int PW   = (DIV  > 1) ? $clog2(DIV)  : 1;
   localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(HALF - 1);

   logic [PW-1:0]             presc;
   logic [1:0]                index;
   logic [BW-1:0]             blink_cnt;
   logic                      phase;
   logic [4*NUM_DIGITS-1:0]   shadow;
   logic [NUM_DIGITS-1:0]     dp_shadow;

   logic                      presc_wrap;
   logic                      blink_wrap;
   logic [3:0]                nibble;
   logic [6:0]                dec_seg;
   logic [NUM_DIGITS-1:0]     lz_blank;
   logic                      dark;
   logic [6:0]                seg_d;
   logic                      dp_d;
   logic [NUM_DIGITS-1:0]     an_d;

   assign presc_wrap = (presc == PRESC_LAST);
   assign blink_wrap = (blink_cnt == BLINK_LAST);
   assign nibble     = shadow[{index, 2'b00} +: 4];

   // A digit is zero-blanked only when it and every digit above it are zero.
   assign lz_blank[3] = blank_lz && (shadow[15:12] == 4'd0);
   assign lz_blank[2] = lz_blank[3] && (shadow[11:8] == 4'd0);
   assign lz_blank[1] = lz_blank[2] && (shadow[7:4] == 4'd0);
   assign lz_blank[0] = 1'b0;

   // The prescaler sits at 0 for exactly the first cycle after an index
   // change, which gives the one-cycle anode dead time for free.
   assign dark = (presc == '0) || (blink_en && phase);

   seg7_decode u_decode (
      .bcd   (nibble),
      .seg_n (dec_seg)
   );

   always_comb begin
      seg_d = dec_seg;
      dp_d  = ~dp_shadow[index];
      an_d  = ~(4'b0001 << index);
      if (lz_blank[index]) begin
         seg_d = SEG_BLANK;
      end
      if (dark) begin
         seg_d = SEG_BLANK;
         dp_d  = 1'b1;
         an_d  = 4'hF;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc     <= '0;
         index     <= 2'd0;
         blink_cnt <= '0;
         phase     <= 1'b0;
         shadow    <= '0;
         dp_shadow <= '0;
         load_ack  <= 1'b0;
         seg_n     <= SEG_BLANK;
         dp_n      <= 1'b1;
         an_n      <= 4'hF;
      end else begin
         presc     <= presc_wrap ? '0 : presc + 1'b1;
         blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
         if (presc_wrap) begin
            index <= index + 2'd1;
         end
         if (blink_wrap) begin
            phase <= ~phase;
         end
         if (load) begin
            shadow    <= digit_in;
            dp_shadow <= dp_in;
         end
         load_ack <= load;
         seg_n    <= seg_d;
         dp_n     <= dp_d;
         an_n     <= an_d;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display against a cycle-count based
// reference model of the scan, blank, dead-time and blink rules.
module tb_seg7_scan_display;

   localparam int CLK_HZ   = 16;
   localparam int SCAN_HZ  = 4;
   localparam int BLINK_HZ = 1;
   localparam int DIV      = CLK_HZ / SCAN_HZ;
   localparam int HALF     = CLK_HZ / (2 * BLINK_HZ);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   seg7_scan_display_if bus();

   seg7_scan_display #(
      .CLK_HZ   (CLK_HZ),
      .SCAN_HZ  (SCAN_HZ),
      .BLINK_HZ (BLINK_HZ)
   ) dut (
      .clk      (clk),
      .reset    (rst),
      .digit_in (bus.digit_in),
      .load     (bus.load),
      .dp_in    (bus.dp_in),
      .blank_lz (bus.blank_lz),
      .blink_en (bus.blink_en),
      .load_ack (bus.load_ack),
      .seg_n    (bus.seg_n),
      .dp_n     (bus.dp_n),
      .an_n     (bus.an_n)
   );

   int tests = 0;
   int fails = 0;

   // Reference model: n = clock edges since reset release.
   int          n;
   logic [15:0] m_shadow;
   logic [3:0]  m_dp;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_an;
   logic        e_ack;

   function automatic logic [6:0] ref_code(input int d);
      case (d)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   function automatic bit ref_dark(input int c, input bit ben);
      return ((c % DIV) == 0) || (ben && (((c / HALF) % 2) == 1));
   endfunction

   function automatic logic [6:0] ref_seg(input int c, input logic [15:0] sh,
                                          input bit lz, input bit ben);
      int i;
      int d;
      i = (c / DIV) % 4;
      d = int'((sh >> (4 * i)) & 16'hF);
      if (ref_dark(c, ben)) return 7'h7F;
      if (lz && i > 0 && (sh >> (4 * i)) == 16'h0) return 7'h7F;
      return ref_code(d);
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         n        <= 0;
         m_shadow <= '0;
         m_dp     <= '0;
         e_seg    <= 7'h7F;
         e_dp     <= 1'b1;
         e_an     <= 4'hF;
         e_ack    <= 1'b0;
      end else begin
         e_ack <= bus.load;
         e_seg <= ref_seg(n, m_shadow, bus.blank_lz, bus.blink_en);
         e_an  <= ref_dark(n, bus.blink_en) ? 4'hF : ~(4'b0001 << ((n / DIV) % 4));
         e_dp  <= ref_dark(n, bus.blink_en) ? 1'b1 : ~m_dp[(n / DIV) % 4];
         if (bus.load) begin
            m_shadow <= bus.digit_in;
            m_dp     <= bus.dp_in;
         end
         n <= n + 1;
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      bus.digit_in = '0; bus.load = 1'b0; bus.dp_in = '0;
      bus.blank_lz = 1'b0; bus.blink_en = 1'b0;
      #2 rst = 1'b0;
      #3;
      tests++;
      if ({bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
         fails++;
         $display("FAIL reset: seg=%h dp=%b an=%h ack=%b, expected 7f/1/f/0",
                  bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [6:0] digit_code [4];
      digit_code = '{7'h19, 7'h30, 7'h24, 7'h79};
      bus.digit_in = 16'h1234; bus.dp_in = 4'h0; bus.load = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         bus.load = 1'b0;
         tests++;
         if ({bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack} !== {e_seg, e_dp, e_an, e_ack}) begin
            fails++;
            $display("FAIL basic c=%0d: seg=%h dp=%b an=%h ack=%b, expected %h/%b/%h/%b",
                     c, bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack, e_seg, e_dp, e_an, e_ack);
         end
         if (c < 2) begin
            tests++;
            if (bus.load_ack !== (c == 0)) begin
               fails++;
               $display("FAIL basic_ack c=%0d: ack=%b, expected %b", c, bus.load_ack, c == 0);
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (bus.an_n === ~(4'b0001 << i)) begin
               tests++;
               if (bus.seg_n !== digit_code[i]) begin
                  fails++;
                  $display("FAIL basic_digit%0d: seg=%h, expected %h", i, bus.seg_n, digit_code[i]);
               end
            end
         end
      end
   endtask

   task automatic test_blank_lz();
      bus.digit_in = 16'h0070; bus.dp_in = 4'h0; bus.blank_lz = 1'b1; bus.load = 1'b1;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         bus.load = 1'b0;
         tests++;
         if ({bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack} !== {e_seg, e_dp, e_an, e_ack}) begin
            fails++;
            $display("FAIL blank_lz c=%0d: seg=%h dp=%b an=%h ack=%b, expected %h/%b/%h/%b",
                     c, bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack, e_seg, e_dp, e_an, e_ack);
         end
      end
   endtask

   task automatic test_hex_blank_dp();
      bus.digit_in = 16'h00AF; bus.dp_in = 4'b0001; bus.blank_lz = 1'b0; bus.load = 1'b1;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         bus.load = 1'b0;
         tests++;
         if ({bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack} !== {e_seg, e_dp, e_an, e_ack}) begin
            fails++;
            $display("FAIL hex_dp c=%0d: seg=%h dp=%b an=%h ack=%b, expected %h/%b/%h/%b",
                     c, bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack, e_seg, e_dp, e_an, e_ack);
         end
         if (c > 0) begin
            tests++;
            if (bus.dp_n !== (bus.an_n !== 4'hE)) begin
               fails++;
               $display("FAIL hex_dp_only_e c=%0d: dp=%b an=%h", c, bus.dp_n, bus.an_n);
            end
         end
      end
   endtask

   task automatic test_blink();
      int dark_run = 0;
      bus.blink_en = 1'b1;
      for (int c = 0; c < 48; c++) begin
         @(negedge clk);
         tests++;
         if ({bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack} !== {e_seg, e_dp, e_an, e_ack}) begin
            fails++;
            $display("FAIL blink c=%0d: seg=%h dp=%b an=%h ack=%b, expected %h/%b/%h/%b",
                     c, bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack, e_seg, e_dp, e_an, e_ack);
         end
         dark_run = (bus.an_n === 4'hF) ? dark_run + 1 : 0;
         if (dark_run > HALF + 1) begin
            tests++;
            fails++;
            $display("FAIL blink_window c=%0d: dark run %0d, expected at most %0d", c, dark_run, HALF + 1);
         end
      end
      bus.blink_en = 1'b0;
   endtask

   task automatic test_load_at_wrap();
      int  k = 0;
      bit  seen_dead = 1'b0;
      bit  checked = 1'b0;
      bus.blank_lz = 1'b0;
      while ((n % DIV) != DIV - 1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (k >= 20) begin
         fails++;
         $display("FAIL wrap_align: no wrap within %0d cycles", k);
      end
      bus.digit_in = 16'h9999; bus.dp_in = 4'h0; bus.load = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         bus.load = 1'b0;
         tests++;
         if ({bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack} !== {e_seg, e_dp, e_an, e_ack}) begin
            fails++;
            $display("FAIL wrap c=%0d: seg=%h dp=%b an=%h ack=%b, expected %h/%b/%h/%b",
                     c, bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack, e_seg, e_dp, e_an, e_ack);
         end
         if (bus.an_n === 4'hF) seen_dead = 1'b1;
         else if (seen_dead && !checked) begin
            checked = 1'b1;
            tests++;
            if (bus.seg_n !== 7'h10) begin
               fails++;
               $display("FAIL wrap_next_digit: seg=%h, expected 10", bus.seg_n);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 28; c++) begin
         if (c < 4) begin
            bus.load = 1'b1;
            bus.digit_in = 16'($urandom_range(0, 65535));
            bus.dp_in = 4'($urandom_range(0, 15));
         end else begin
            bus.load = 1'b0;
         end
         @(negedge clk);
         tests++;
         if ({bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack} !== {e_seg, e_dp, e_an, e_ack}) begin
            fails++;
            $display("FAIL b2b c=%0d: seg=%h dp=%b an=%h ack=%b, expected %h/%b/%h/%b",
                     c, bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack, e_seg, e_dp, e_an, e_ack);
         end
         if (c < 5) begin
            tests++;
            if (bus.load_ack !== (c < 4)) begin
               fails++;
               $display("FAIL b2b_ack c=%0d: ack=%b, expected %b", c, bus.load_ack, c < 4);
            end
         end
      end
      bus.load = 1'b0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         bus.load = ($urandom_range(0, 3) == 0);
         bus.digit_in = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
         bus.dp_in = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) bus.blank_lz = ~bus.blank_lz;
         if ($urandom_range(0, 39) == 0) bus.blink_en = ~bus.blink_en;
         @(negedge clk);
         tests++;
         if ({bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack} !== {e_seg, e_dp, e_an, e_ack}) begin
            fails++;
            $display("FAIL random c=%0d: seg=%h dp=%b an=%h ack=%b, expected %h/%b/%h/%b",
                     c, bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack, e_seg, e_dp, e_an, e_ack);
         end
      end
      bus.load = 1'b0;
      bus.blink_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      int  k = 0;
      bit  first_seen = 1'b0;
      bus.digit_in = 16'h5678; bus.dp_in = 4'h0; bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
      while (bus.an_n !== 4'hB && k < 60) begin
         @(negedge clk);
         k++;
      end
      tests++;
      if (k >= 60) begin
         fails++;
         $display("FAIL reset_mid_wait: an=%h never reached b", bus.an_n);
      end
      #2 rst = 1'b0;
      #1;
      tests++;
      if ({bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
         fails++;
         $display("FAIL reset_mid: seg=%h dp=%b an=%h ack=%b, expected 7f/1/f/0",
                  bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         tests++;
         if ({bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack} !== {e_seg, e_dp, e_an, e_ack}) begin
            fails++;
            $display("FAIL reset_mid_after c=%0d: seg=%h dp=%b an=%h ack=%b, expected %h/%b/%h/%b",
                     c, bus.seg_n, bus.dp_n, bus.an_n, bus.load_ack, e_seg, e_dp, e_an, e_ack);
         end
         if (bus.an_n !== 4'hF && !first_seen) begin
            first_seen = 1'b1;
            tests++;
            if (bus.an_n !== 4'hE || bus.seg_n !== 7'h40) begin
               fails++;
               $display("FAIL reset_mid_first: an=%h seg=%h, expected e/40", bus.an_n, bus.seg_n);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_blank_lz();
      test_hex_blank_dp();
      test_blink();
      test_load_at_wrap();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
